tis_debug_mon_arbiter: RTL and testbench

//  Shares the single OCI monitor-memory port between two requesters: the JTAG debug

---
 rtl/tis_debug_pkg.sv | 18 +
 rtl/tis_debug_rr_arb2.sv | 24 ++
 rtl/tis_debug_mon_arbiter.sv | 149 ++++++++++++++
 tb/tb_tis_debug_mon_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tis_debug_pkg.sv
// Shared types for the TIS debug monitor-port arbiter: FSM states, requester
// identity and the default abort timeout.
package tis_debug_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_JTAG  = 1'b0,
        OWN_LOCAL = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/tis_debug_rr_arb2.sv
// Two-way round-robin grant between the JTAG and local requesters; purely
// combinational, the previous-owner state is kept by the parent.
module tis_debug_rr_arb2
    import tis_debug_pkg::*;
(
    input  logic   i_j_req,
    input  logic   i_l_req,
    input  owner_t i_last_owner,
    output logic   o_gnt_vld,
    output owner_t o_gnt
);

    always_comb begin
        o_gnt_vld = i_j_req | i_l_req;
        o_gnt     = OWN_JTAG;
        // On a tie the requester that did not win last time is served.
        if (i_j_req && i_l_req) begin
            o_gnt = (i_last_owner == OWN_JTAG) ? OWN_LOCAL : OWN_JTAG;
        end else if (i_l_req) begin
            o_gnt = OWN_LOCAL;
        end
    end

endmodule

// File: rtl/tis_debug_mon_arbiter.sv
// Shares the OCI monitor-memory port between the JTAG debug path and a local
// on-chip requester: one outstanding access, round-robin grant, ack timeout.
module tis_debug_mon_arbiter
    import tis_debug_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              j_req,
    input  logic              j_write,
    input  logic [ADDR_W-1:0] j_addr,
    input  logic [DATA_W-1:0] j_wdata,
    output logic              j_done,
    output logic [DATA_W-1:0] j_rdata,
    input  logic              l_req,
    input  logic              l_write,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    output logic              m_req,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            r_last_owner;
    logic [TO_W-1:0]   r_cnt;
    logic              r_timed_out;
    logic              r_m_write;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_j_rdata;
    logic [DATA_W-1:0] r_l_rdata;
    logic              r_mon_ready;
    logic              r_mon_error;

    logic              w_gnt_vld;
    owner_t            w_gnt;
    logic              w_finish;
    logic [DATA_W-1:0] w_rdata_cap;

    tis_debug_rr_arb2 u_arb (
        .i_j_req      (j_req),
        .i_l_req      (l_req),
        .i_last_owner (r_last_owner),
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt        (w_gnt)
    );

    // An ack on the last permitted cycle still counts as success.
    assign w_finish    = m_ack || (r_cnt == CNT_LAST);
    assign w_rdata_cap = (m_ack && !r_m_write) ? m_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_vld) w_state_nxt = BUSY;
            BUSY:    if (w_finish)  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_JTAG;
            r_last_owner <= OWN_LOCAL;
            r_cnt        <= '0;
            r_timed_out  <= 1'b0;
            r_m_write    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_j_rdata    <= '0;
            r_l_rdata    <= '0;
            r_mon_ready  <= 1'b0;
            r_mon_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner      <= w_gnt;
                        r_last_owner <= w_gnt;
                        r_cnt        <= '0;
                        r_m_write    <= (w_gnt == OWN_JTAG) ? j_write : l_write;
                        r_m_addr     <= (w_gnt == OWN_JTAG) ? j_addr  : l_addr;
                        r_m_wdata    <= (w_gnt == OWN_JTAG) ? j_wdata : l_wdata;
                        if (w_gnt == OWN_JTAG) begin
                            r_mon_ready <= 1'b0;
                            r_mon_error <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (w_finish) begin
                        r_timed_out <= !m_ack;
                        if (r_owner == OWN_JTAG) begin
                            r_j_rdata   <= w_rdata_cap;
                            r_mon_ready <= m_ack;
                            r_mon_error <= !m_ack;
                        end else begin
                            r_l_rdata   <= w_rdata_cap;
                        end
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_req         = (r_state == BUSY);
    assign busy          = (r_state != IDLE);
    assign j_done        = (r_state == RESP) && (r_owner == OWN_JTAG);
    assign l_done        = (r_state == RESP) && (r_owner == OWN_LOCAL);
    assign l_err         = l_done && r_timed_out;
    assign m_write       = r_m_write;
    assign m_addr        = r_m_addr;
    assign m_wdata       = r_m_wdata;
    assign j_rdata       = r_j_rdata;
    assign l_rdata       = r_l_rdata;
    assign monitor_ready = r_mon_ready;
    assign monitor_error = r_mon_error;

endmodule

// File: tb/tb_tis_debug_mon_arbiter.sv
// Self-checking bench for tis_debug_mon_arbiter: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_tis_debug_mon_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        j_req, j_write, j_done;
    logic [7:0]  j_addr;
    logic [31:0] j_wdata, j_rdata;
    logic        l_req, l_write, l_done, l_err;
    logic [7:0]  l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic        m_req, m_write, m_ack;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        monitor_ready, monitor_error, busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who won the previous grant, held rdata, JTAG flags.
    bit          last_j;
    logic [31:0] exp_jr, exp_lr;
    bit          exp_mr, exp_me;

    always #5 clk = ~clk;

    tis_debug_mon_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .j_req(j_req), .j_write(j_write), .j_addr(j_addr), .j_wdata(j_wdata),
        .j_done(j_done), .j_rdata(j_rdata),
        .l_req(l_req), .l_write(l_write), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_done(l_done), .l_rdata(l_rdata), .l_err(l_err),
        .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access: present requests in IDLE, answer from the memory side
    // with an ack on BUSY cycle ack_at (never if outside 1..TO), then check RESP.
    task automatic run_txn(input bit jr, input bit lr,
                           input bit jw, input logic [7:0] ja, input logic [31:0] jd,
                           input bit lw, input logic [7:0] la, input logic [31:0] ld,
                           input int ack_at, input logic [31:0] mrd);
        bit          gj;
        bit          ok;
        logic [31:0] rd;
        gj = (jr && lr) ? !last_j : jr;
        j_req = jr; j_write = jw; j_addr = ja; j_wdata = jd;
        l_req = lr; l_write = lw; l_addr = la; l_wdata = ld;
        m_ack = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
        chk("idle_busy", busy, 0);
        step();
        m_ack = 1'b0;
        last_j = gj;
        if (gj) begin
            exp_mr = 1'b0;
            exp_me = 1'b0;
        end
        ok = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            chk("m_req_busy", m_req, 1);
            chk("busy_busy", busy, 1);
            chk("m_addr", m_addr, gj ? ja : la);
            chk("m_write", m_write, gj ? jw : lw);
            chk("m_wdata", m_wdata, gj ? jd : ld);
            chk("done_in_busy", {j_done, l_done}, 2'b00);
            chk("mon_flags_busy", {monitor_ready, monitor_error}, {exp_mr, exp_me});
            if (c == ack_at) begin
                m_ack = 1'b1;
                m_rdata = mrd;
                ok = 1'b1;
            end
            j_addr = 8'($urandom); l_addr = 8'($urandom);
            j_wdata = $urandom; l_wdata = $urandom;
            j_write = 1'($urandom_range(0, 1)); l_write = 1'($urandom_range(0, 1));
            step();
            m_ack = 1'b0;
            m_rdata = $urandom;
            if (ok) break;
        end
        rd = (ok && !(gj ? jw : lw)) ? mrd : 32'h0;
        if (gj) begin
            exp_jr = rd;
            exp_mr = ok;
            exp_me = !ok;
        end else begin
            exp_lr = rd;
        end
        chk("m_req_resp", m_req, 0);
        chk("busy_resp", busy, 1);
        chk("j_done", j_done, gj);
        chk("l_done", l_done, !gj);
        chk("l_err", l_err, !gj && !ok);
        chk("j_rdata", j_rdata, exp_jr);
        chk("l_rdata", l_rdata, exp_lr);
        chk("mon_flags_resp", {monitor_ready, monitor_error}, {exp_mr, exp_me});
        j_req = 1'b0;
        l_req = 1'b0;
        m_ack = 1'($urandom_range(0, 1));
        step();
        m_ack = 1'b0;
        chk("busy_after", busy, 0);
        chk("done_after", {j_done, l_done, l_err}, 3'b000);
        chk("m_req_after", m_req, 0);
        chk("j_rdata_held", j_rdata, exp_jr);
        chk("l_rdata_held", l_rdata, exp_lr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        j_req = 0; j_write = 0; j_addr = 0; j_wdata = 0;
        l_req = 0; l_write = 0; l_addr = 0; l_wdata = 0;
        m_ack = 0; m_rdata = 0;
        last_j = 1'b0; exp_jr = 0; exp_lr = 0; exp_mr = 0; exp_me = 0;
        step();
        step();
        chk("rst_ctrl", {m_req, busy, j_done, l_done, l_err, monitor_ready, monitor_error}, 7'd0);
        chk("rst_mdata", {m_write, m_addr, m_wdata}, 41'd0);
        chk("rst_rdata", {j_rdata, l_rdata}, 64'd0);
        reset = 1'b0;
        step();

        // Tied requests straight after reset: JTAG first, then strict alternation.
        for (int i = 0; i < 8; i++) begin
            run_txn(1, 1, 0, 8'(8'h20 + i), $urandom, 1, 8'(8'h40 + i), $urandom, 1, $urandom);
        end

        // JTAG read, ack on third BUSY cycle.
        run_txn(1, 0, 0, 8'h12, 32'h0, 0, 8'h0, 32'h0, 3, 32'hCAFEF00D);
        chk("t1_rdata", j_rdata, 32'hCAFEF00D);

        // No ack: timeout after TO BUSY cycles; the next JTAG grant clears the error.
        run_txn(1, 0, 0, 8'h77, 32'h0, 0, 8'h0, 32'h0, 0, 32'hDEADBEEF);
        chk("t3_err", monitor_error, 1);

        // Ack on the final permitted cycle wins.
        run_txn(1, 0, 0, 8'h78, 32'h0, 0, 8'h0, 32'h0, TO, 32'h5A5A5A5A);
        chk("t4_flags", {monitor_ready, monitor_error}, 2'b10);

        // Local write leaves the JTAG flags alone.
        run_txn(0, 1, 0, 8'h0, 32'h0, 1, 8'h05, 32'h00001234, 1, 32'hFFFFFFFF);
        chk("t6_flags", {monitor_ready, monitor_error}, 2'b10);

        // Reset on the second BUSY cycle of a JTAG read.
        j_req = 1'b1; j_write = 1'b0; j_addr = 8'h33; j_wdata = 32'h0;
        step();
        chk("t5_busy1", m_req, 1);
        step();
        chk("t5_busy2", m_req, 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_mreq", m_req, 0);
        chk("t5_async_busy", busy, 0);
        j_req = 1'b0;
        #2 reset = 1'b0;
        step();
        chk("t5_no_done", {j_done, busy, monitor_ready, monitor_error}, 4'b0000);
        chk("t5_rdata", j_rdata, 32'h0);
        last_j = 1'b0; exp_jr = 0; exp_lr = 0; exp_mr = 0; exp_me = 0;
        run_txn(1, 1, 0, 8'h44, 32'h0, 0, 8'h45, 32'h0, 2, 32'h01234567);
        chk("t5_jtag_won", j_rdata, 32'h01234567);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            bit jr, lr;
            jr = 1'($urandom_range(0, 1));
            lr = jr ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(jr, lr, 1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                    1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                    int'($urandom_range(0, 20)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
